// File: rtl/vx_dot8_accum_if.sv
// Stream bundle for the DOT8 accumulator: result input, flush control and
// the registered accumulator output.
interface vx_dot8_accum_if #(
  parameter int NUM_WARPS  = 4,
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                            in_valid;
  logic                            in_ready;
  logic [NW_BITS-1:0]              in_wid;
  logic [NUM_LANES-1:0]            in_tmask;
  logic                            in_clear;
  logic [NUM_LANES*DATA_WIDTH-1:0] in_data;
  logic                            flush;
  logic                            flush_busy;
  logic                            out_valid;
  logic                            out_ready;
  logic [NW_BITS-1:0]              out_wid;
  logic [NUM_LANES-1:0]            out_tmask;
  logic [NUM_LANES*DATA_WIDTH-1:0] out_data;

  // Producer of results / consumer of accumulator values.
  modport master (
    output in_valid, in_wid, in_tmask, in_clear, in_data, flush, out_ready,
    input  in_ready, flush_busy, out_valid, out_wid, out_tmask, out_data
  );

  // The accumulator block itself.
  modport slave (
    input  in_valid, in_wid, in_tmask, in_clear, in_data, flush, out_ready,
    output in_ready, flush_busy, out_valid, out_wid, out_tmask, out_data
  );
endinterface

// File: rtl/vx_dot8_accum.sv
// Per-warp, per-lane accumulator behind the DOT8 commit path. Adds (or
// overwrites) each result vector into its warp's accumulators and presents
// the updated values through a one-deep output register.
//
//  state   | meaning
//  S_FLUSH | walking r_fcnt over all warps, zeroing one warp per cycle
//  S_IDLE  | accepting results
module vx_dot8_accum #(
  parameter int NUM_WARPS  = 4,
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SATURATE   = 1
) (
  input  logic             clk,
  input  logic             reset,
  vx_dot8_accum_if.slave   bus
);
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int DW      = DATA_WIDTH;

  typedef enum logic {S_FLUSH, S_IDLE} state_t;

  state_t                      r_state, w_state_nxt;
  logic [NW_BITS-1:0]          r_fcnt, w_fcnt_nxt;
  logic                        w_in_ready, w_flush_busy, w_accept;
  logic [DW-1:0]               r_acc [NUM_WARPS][NUM_LANES];
  logic [NUM_LANES*DW-1:0]     w_new;
  logic                        r_out_valid;
  logic [NW_BITS-1:0]          r_out_wid;
  logic [NUM_LANES-1:0]        r_out_tmask;
  logic [NUM_LANES*DW-1:0]     r_out_data;

  // Signed add, clamped to the representable range when SATURATE is set.
  function automatic logic [DW-1:0] f_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] s;
    s = a + b;
    if (SATURATE != 0 && (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]))
      s = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return s;
  endfunction

  // State register and flush walk counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FLUSH;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Next state, walk counter and handshake outputs; flush beats a same-cycle input.
  always_comb begin
    w_state_nxt  = r_state;
    w_fcnt_nxt   = r_fcnt;
    w_flush_busy = 1'b0;
    w_in_ready   = 1'b0;
    case (r_state)
      S_FLUSH: begin
        w_flush_busy = 1'b1;
        if (r_fcnt == NW_BITS'(NUM_WARPS - 1)) begin
          w_state_nxt = S_IDLE;
          w_fcnt_nxt  = '0;
        end else begin
          w_fcnt_nxt  = r_fcnt + 1'b1;
        end
      end
      S_IDLE: begin
        w_in_ready = !bus.flush && (!r_out_valid || bus.out_ready);
        if (bus.flush) begin
          w_state_nxt = S_FLUSH;
          w_fcnt_nxt  = '0;
        end
      end
      default: w_state_nxt = S_FLUSH;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;

  // Per-lane update value; inactive lanes pass the current accumulator through.
  always_comb begin
    w_new = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (!bus.in_tmask[l])
        w_new[l*DW +: DW] = r_acc[bus.in_wid][l];
      else if (bus.in_clear)
        w_new[l*DW +: DW] = bus.in_data[l*DW +: DW];
      else
        w_new[l*DW +: DW] = f_add(r_acc[bus.in_wid][l], bus.in_data[l*DW +: DW]);
    end
  end

  // Accumulator file: no reset, the walk clears it; writes land in the accept
  // cycle so back-to-back results for one warp chain without a bypass.
  always_ff @(posedge clk) begin
    if (r_state == S_FLUSH) begin
      for (int l = 0; l < NUM_LANES; l++) r_acc[r_fcnt][l] <= '0;
    end else if (w_accept) begin
      for (int l = 0; l < NUM_LANES; l++) r_acc[bus.in_wid][l] <= w_new[l*DW +: DW];
    end
  end

  // One-deep output register; holds while stalled, drains even during a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_wid   <= '0;
      r_out_tmask <= '0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_wid   <= bus.in_wid;
      r_out_tmask <= bus.in_tmask;
      r_out_data  <= w_new;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.flush_busy = w_flush_busy;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_wid    = r_out_wid;
  assign bus.out_tmask  = r_out_tmask;
  assign bus.out_data   = r_out_data;

  // Warp ids beyond the tracked range are illegal.
  a_wid_range: assert property (@(posedge clk) disable iff (reset)
    bus.in_valid |-> ({1'b0, bus.in_wid} < (NW_BITS+1)'(NUM_WARPS)));

endmodule
